lzc_stream: RTL and testbench
=============================

Name: lzc_stream

Overview:
- Streaming leading-zero/leading-one counter over a multi-word frame with valid/ready handshakes on both input and output.
- Successor to the fixed-length LZC. Adds:
  - parametrised word width and maximum frame length
  - a run-time frame length
  - count polarity
  - an all-zero flag
  - output backpressure
- Sits between the datapath word streamer and the normalisation/shift stage.

Parameters:
- WIDTH, 8, bits per input word (≥2).
- MAX_WORDS, 64, maximum words per frame (≥1).
- NW_W, $clog2(MAX_WORDS+1), width of the NWORDS input.
- CNT_W, $clog2(WIDTH*MAX_WORDS+1), width of the COUNT output.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- MODE  in  1  0 = full frame always consumed; 1 = frame ends at the first word containing a target-polarity-breaking bit.
- POL  in  1  0 = count leading zeros; 1 = count leading ones.
- NWORDS  in  NW_W  frame length, sampled on the first beat. 0 or >MAX_WORDS is treated as MAX_WORDS.
- IVALID  in  1  input word valid.
- IREADY  out  1  block can accept a word.
- DATA  in  WIDTH  input word, MSB first in time and significance.
- OVALID  out  1  result valid.
- OREADY  in  1  downstream accepts the result.
- COUNT  out  CNT_W  leading count for the frame.
- ALL_SAME  out  1  no breaking bit found in any consumed word.

Behaviour:
- Reset values (asynchronous, immediate):
  - OVALID=0, COUNT=0, ALL_SAME=0, IREADY=0.
  - Internal accumulator, word counter, found flag and latched NWORDS/MODE/POL all cleared; state=IDLE.
  - IREADY goes 1 on the first clock edge after reset is released.
- Beat rule: a beat is IVALID&&IREADY at a rising edge. DATA is ignored when there is no beat.
- Word count: per beat, lz = number of leading bits equal to POL before the first bit ≠ POL. lz=WIDTH if the word has no breaking bit.
- State machine:
  - IDLE: IREADY=1. On a beat:
    - latch NWORDS (normalised), MODE and POL
    - acc=lz, words=1, found=(lz<WIDTH)
    - go to DONE if the end condition holds, else ACCUM.
  - ACCUM: IREADY=1. On a beat:
    - words++
    - if !found, acc+=lz; if found, acc is unchanged
    - found|=(lz<WIDTH)
    - go to DONE on the end condition.
  - End condition (evaluated on the current beat, including the word just consumed): (words==NWORDS_latched) || (MODE_latched && found).
  - DONE: IREADY=0, OVALID=1, COUNT=acc, ALL_SAME=!found. All three are registered and held stable until OREADY. When OVALID&&OREADY, go to IDLE.
- Accepting the next frame in the cycle right after the handshake is allowed (the IDLE IREADY=1 on the next cycle). No same-cycle pass-through.
- Latency: OVALID rises on the edge after the final beat, one cycle. Throughput: at most one frame per (N+1) cycles with OREADY held high.
- MODE/POL/NWORDS changes mid-frame are ignored (latched values are used).
- IVALID gaps mid-frame stall the frame with no timeout; the accumulator holds.
- Arithmetic: acc is CNT_W bits and cannot overflow (max WIDTH*MAX_WORDS).
- Reset asserted mid-frame or mid-DONE aborts the frame; no partial output.

Optional Feature:
- Macro: LZC_FIRST_IDX_EN.
- Defined:
  - Adds output FIRST_IDX, width $clog2(MAX_WORDS), reset 0: the 0-based index of the first word containing a breaking bit.
  - Valid with OVALID; 0 when ALL_SAME=1.
  - Costs one index register captured on the beat where found rises.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package lzc_pkg: state enum (IDLE, ACCUM, DONE) and POL encodings.
- Sub-module lzc_word: combinational, parameter WIDTH, inputs DATA and POL, outputs lz and has_break. It is a priority encoder, reused by the normaliser.
- lzc_stream holds the FSM, counters and output registers.

Test Plan:
- WIDTH=8, POL=0, MODE=0, NWORDS=4, words 00,00,1F,FF -> COUNT=19, ALL_SAME=0, OVALID one cycle after beat 4.
- Same words, MODE=1 -> frame ends on beat 3, COUNT=19, IREADY=0 from the next cycle, 4th word not consumed.
- POL=1, NWORDS=2, words FF,E0 -> COUNT=11. Then POL=0, NWORDS=3, all 00 -> COUNT=24, ALL_SAME=1.
- NWORDS=0 with MAX_WORDS=4, all 00 -> 4 beats consumed, COUNT=32.
- OREADY held low 5 cycles; random IVALID gaps -> COUNT/OVALID stable, IREADY=0, no beats lost or duplicated. A back-to-back frame starts the cycle after the handshake.
- RST_N pulsed after 2 beats of a 4-word frame -> all outputs 0 immediately; next frame of 01,00,00,00 gives COUNT=7 (with LZC_FIRST_IDX_EN: FIRST_IDX=0).

Source files
------------

// File: rtl/lzc_pkg.sv
// lzc_pkg: shared types for the streaming leading-count block.
// State encoding for the frame FSM plus the POL and MODE input encodings.
package lzc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } lzc_state_t;

  // POL: which bit value forms the run being counted
  localparam logic POL_ZEROS = 1'b0;
  localparam logic POL_ONES  = 1'b1;

  // MODE: 1 ends the frame at the first word holding a breaking bit
  localparam logic MODE_EARLY = 1'b1;

endpackage

// File: rtl/lzc_stream_if.sv
// lzc_stream_if: frame-input and result-output handshake bundle.
// Optional macro LZC_FIRST_IDX_EN adds the FIRST_IDX result field.
interface lzc_stream_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 64
);
  localparam int NW_W  = $clog2(MAX_WORDS + 1);
  localparam int CNT_W = $clog2(WIDTH * MAX_WORDS + 1);
`ifdef LZC_FIRST_IDX_EN
  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
`endif

  // input side: per-frame configuration and word stream
  logic             MODE;
  logic             POL;
  logic [NW_W-1:0]  NWORDS;
  logic             IVALID;
  logic             IREADY;
  logic [WIDTH-1:0] DATA;

  // output side: frame result
  logic             OVALID;
  logic             OREADY;
  logic [CNT_W-1:0] COUNT;
  logic             ALL_SAME;
`ifdef LZC_FIRST_IDX_EN
  logic [IDX_W-1:0] FIRST_IDX;
`endif

`ifdef LZC_FIRST_IDX_EN
  modport master (
    output MODE, POL, NWORDS, IVALID, DATA, OREADY,
    input  IREADY, OVALID, COUNT, ALL_SAME, FIRST_IDX
  );
  modport slave (
    input  MODE, POL, NWORDS, IVALID, DATA, OREADY,
    output IREADY, OVALID, COUNT, ALL_SAME, FIRST_IDX
  );
`else
  modport master (
    output MODE, POL, NWORDS, IVALID, DATA, OREADY,
    input  IREADY, OVALID, COUNT, ALL_SAME
  );
  modport slave (
    input  MODE, POL, NWORDS, IVALID, DATA, OREADY,
    output IREADY, OVALID, COUNT, ALL_SAME
  );
`endif

endinterface

// File: rtl/lzc_word.sv
// lzc_word: single-word leading-run priority encoder.
// lz counts MSB-first bits equal to POL; lz == WIDTH when no breaking bit exists.
module lzc_word
  import lzc_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int LZ_W  = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] DATA,
  input  logic             POL,
  output logic [LZ_W-1:0]  lz,
  output logic             has_break
);

  // breaking bits become ones, so the job reduces to a leading-zero count
  logic [WIDTH-1:0] brk;

  assign brk       = (POL == POL_ONES) ? ~DATA : DATA;
  assign has_break = |brk;

  // priority encode: scanning upward, the most significant breaking bit is the last to write
  always_comb begin
    lz = LZ_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (brk[i]) lz = LZ_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/lzc_stream.sv
// lzc_stream: streaming leading-zero/leading-one counter over a multi-word frame.
// Optional macro LZC_FIRST_IDX_EN adds FIRST_IDX, the index of the first breaking word.
module lzc_stream
  import lzc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 64
) (
  input logic         CLK,
  input logic         RST_N,
  lzc_stream_if.slave bus
);

  localparam int NW_W  = $clog2(MAX_WORDS + 1);
  localparam int CNT_W = $clog2(WIDTH * MAX_WORDS + 1);
  localparam int LZ_W  = $clog2(WIDTH + 1);
`ifdef LZC_FIRST_IDX_EN
  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
`endif

  lzc_state_t       state_reg, state_next;
  logic [CNT_W-1:0] acc_reg, acc_next;
  logic [NW_W-1:0]  words_reg, words_next;
  logic [NW_W-1:0]  nwords_reg, nwords_next;
  logic             found_reg, found_next;
  logic             mode_reg, mode_next;
  logic             pol_reg, pol_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             all_same_reg, all_same_next;
  logic             iready_reg;
  logic             ovalid_reg;
`ifdef LZC_FIRST_IDX_EN
  logic [IDX_W-1:0] idx_reg, idx_next;
`endif

  logic             beat;
  logic             word_pol;
  logic [LZ_W-1:0]  lz;
  logic             has_break;
  logic             end_frame;
  logic [NW_W-1:0]  nwords_norm;

  assign beat = bus.IVALID && iready_reg;

  // the first beat of a frame uses the live POL; later beats use the latched one
  assign word_pol = (state_reg == IDLE) ? bus.POL : pol_reg;

  // out-of-range frame lengths fall back to the maximum
  assign nwords_norm = ((bus.NWORDS == '0) || (bus.NWORDS > NW_W'(MAX_WORDS)))
                     ? NW_W'(MAX_WORDS) : bus.NWORDS;

  lzc_word #(
    .WIDTH (WIDTH)
  ) u_word (
    .DATA      (bus.DATA),
    .POL       (word_pol),
    .lz        (lz),
    .has_break (has_break)
  );

  // next-state and datapath update for each accepted word
  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    words_next    = words_reg;
    nwords_next   = nwords_reg;
    found_next    = found_reg;
    mode_next     = mode_reg;
    pol_next      = pol_reg;
    count_next    = count_reg;
    all_same_next = all_same_reg;
    end_frame     = 1'b0;
`ifdef LZC_FIRST_IDX_EN
    idx_next      = idx_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (beat) begin
          nwords_next = nwords_norm;
          mode_next   = bus.MODE;
          pol_next    = bus.POL;
          acc_next    = CNT_W'(lz);
          words_next  = NW_W'(1);
          found_next  = has_break;
`ifdef LZC_FIRST_IDX_EN
          idx_next    = '0;
`endif
          end_frame   = (nwords_norm == NW_W'(1)) ||
                        ((bus.MODE == MODE_EARLY) && has_break);
          state_next  = end_frame ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          words_next = words_reg + 1'b1;
          // once the run is broken, later words no longer contribute
          if (!found_reg) acc_next = acc_reg + CNT_W'(lz);
          found_next = found_reg | has_break;
`ifdef LZC_FIRST_IDX_EN
          if (!found_reg && has_break) idx_next = IDX_W'(words_reg);
`endif
          end_frame  = (words_next == nwords_reg) ||
                       ((mode_reg == MODE_EARLY) && found_next);
          if (end_frame) state_next = DONE;
        end
      end
      DONE: begin
        // OVALID is high for the whole of DONE, so OREADY alone completes the handshake
        if (bus.OREADY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (end_frame) begin
      count_next    = acc_next;
      all_same_next = !found_next;
    end
  end

  // state, accumulator and registered outputs; reset aborts any frame in flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      words_reg    <= '0;
      nwords_reg   <= '0;
      found_reg    <= 1'b0;
      mode_reg     <= 1'b0;
      pol_reg      <= 1'b0;
      count_reg    <= '0;
      all_same_reg <= 1'b0;
      iready_reg   <= 1'b0;
      ovalid_reg   <= 1'b0;
`ifdef LZC_FIRST_IDX_EN
      idx_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      words_reg    <= words_next;
      nwords_reg   <= nwords_next;
      found_reg    <= found_next;
      mode_reg     <= mode_next;
      pol_reg      <= pol_next;
      count_reg    <= count_next;
      all_same_reg <= all_same_next;
      // handshake flags are registered so IREADY stays low until the first edge after reset
      iready_reg   <= (state_next != DONE);
      ovalid_reg   <= (state_next == DONE);
`ifdef LZC_FIRST_IDX_EN
      idx_reg      <= idx_next;
`endif
    end
  end

  assign bus.IREADY   = iready_reg;
  assign bus.OVALID   = ovalid_reg;
  assign bus.COUNT    = count_reg;
  assign bus.ALL_SAME = all_same_reg;
`ifdef LZC_FIRST_IDX_EN
  assign bus.FIRST_IDX = idx_reg;
`endif

endmodule

// File: tb/tb_lzc_stream.sv
// tb_lzc_stream: randomized and directed checks of lzc_stream against a bit-level frame model.
// Honours LZC_FIRST_IDX_EN when the build defines it.
`timescale 1ns/1ps
module tb_lzc_stream;

  localparam int WIDTH = 8;
  localparam int MAXW  = 4;
  localparam int NW_W  = $clog2(MAXW + 1);
  localparam int CNT_W = $clog2(WIDTH * MAXW + 1);

  logic clk = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  lzc_stream_if #(.WIDTH(WIDTH), .MAX_WORDS(MAXW)) bus ();

  lzc_stream #(
    .WIDTH     (WIDTH),
    .MAX_WORDS (MAXW)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // frame contents and results of the latest run
  logic [WIDTH-1:0] frame_words [MAXW];
  int               r_beats, r_lat, r_cyc;
  logic [CNT_W-1:0] r_count;
  logic             r_all_same;
  logic [7:0]       r_fidx;
  bit               r_stable, r_timeout, r_iready_done, r_iready_after, r_ovalid_after;

  // model expectations
  int  e_beats, e_count, e_fidx;
  bit  e_all_same;

  // reference: walk the frame bit by bit, MSB-first, counting the leading run
  task automatic model(input int nwords, input bit mode, input bit pol);
    int n;
    bit found;
    n = (nwords == 0 || nwords > MAXW) ? MAXW : nwords;
    e_count = 0; e_fidx = 0; e_beats = n; found = 0;
    for (int w = 0; w < n; w++) begin
      for (int b = WIDTH - 1; b >= 0; b--) begin
        if (!found) begin
          if (frame_words[w][b] == pol) e_count++;
          else begin found = 1; e_fidx = w; end
        end
      end
      if (mode && found) begin e_beats = w + 1; break; end
    end
    e_all_same = !found;
  endtask

  function automatic logic [WIDTH-1:0] rand_word(input bit pol);
    logic [WIDTH-1:0] w;
    int k;
    case ($urandom_range(0, 3))
      0, 2: w = {WIDTH{pol}};
      1:    w = WIDTH'($urandom);
      default: begin
        k = $urandom_range(0, WIDTH - 1);
        w = {WIDTH{pol}};
        w[k] = ~pol;
      end
    endcase
    return w;
  endfunction

  // drives one frame starting at the current negedge, then holds OREADY low and handshakes
  task automatic run_frame(input int frame_len, input int nwords, input bit mode, input bit pol,
                           input int gap_pct, input int hold);
    int  idx, cyc, last_drive;
    bit  give, beat_pending;
    r_beats = 0; idx = 0; cyc = 0; last_drive = 0;
    r_stable = 1; r_timeout = 0; r_iready_done = 1; r_iready_after = 0; r_ovalid_after = 1;
    r_fidx = '0;
    bus.MODE = mode; bus.POL = pol; bus.NWORDS = NW_W'(nwords); bus.OREADY = 1'b0;
    while (bus.OVALID !== 1'b1) begin
      if (cyc >= 400) begin r_timeout = 1; break; end
      give = (idx < frame_len) && ($urandom_range(0, 99) >= gap_pct);
      bus.IVALID = give;
      bus.DATA   = give ? frame_words[idx] : WIDTH'($urandom);
      beat_pending = give && (bus.IREADY === 1'b1);
      if (beat_pending) last_drive = cyc;
      @(negedge clk);
      cyc++;
      if (beat_pending) begin
        idx++; r_beats++;
        // configuration churn after the first beat must not affect this frame
        bus.MODE = 1'($urandom); bus.POL = 1'($urandom); bus.NWORDS = NW_W'($urandom);
      end
    end
    r_lat = cyc - last_drive;
    r_cyc = cyc;
    r_count = bus.COUNT;
    r_all_same = bus.ALL_SAME;
`ifdef LZC_FIRST_IDX_EN
    r_fidx = 8'(bus.FIRST_IDX);
`endif
    r_iready_done = bus.IREADY;
    if (!r_timeout) begin
      for (int h = 0; h < hold; h++) begin
        bus.IVALID = 1'b1; bus.DATA = WIDTH'($urandom);
        if (bus.IREADY !== 1'b0) r_stable = 0;
        @(negedge clk);
        if (bus.OVALID !== 1'b1 || bus.COUNT !== r_count || bus.ALL_SAME !== r_all_same ||
            bus.IREADY !== 1'b0) r_stable = 0;
      end
      bus.IVALID = 1'b0; bus.OREADY = 1'b1;
      @(negedge clk);
      bus.OREADY = 1'b0;
      r_ovalid_after = bus.OVALID;
      r_iready_after = bus.IREADY;
    end
    $display("frame nwords=%0d mode=%0d pol=%0d beats=%0d count=%0d all_same=%0d first_idx=%0d",
             nwords, mode, pol, r_beats, r_count, r_all_same, r_fidx);
  endtask

  task automatic test_reset();
    bus.IVALID = 0; bus.OREADY = 0; bus.MODE = 0; bus.POL = 0; bus.NWORDS = '0; bus.DATA = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.OVALID !== 1'b0) begin n_fail++; $display("FAIL reset_ovalid: got %b want 0", bus.OVALID); end
    n_checks++; if (bus.COUNT !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.COUNT); end
    n_checks++; if (bus.ALL_SAME !== 1'b0) begin n_fail++; $display("FAIL reset_all_same: got %b want 0", bus.ALL_SAME); end
    n_checks++; if (bus.IREADY !== 1'b0) begin n_fail++; $display("FAIL reset_iready: got %b want 0", bus.IREADY); end
`ifdef LZC_FIRST_IDX_EN
    n_checks++; if (bus.FIRST_IDX !== '0) begin n_fail++; $display("FAIL reset_first_idx: got %0d want 0", bus.FIRST_IDX); end
`endif
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.IREADY !== 1'b0) begin n_fail++; $display("FAIL release_iready_before_edge: got %b want 0", bus.IREADY); end
    @(negedge clk);
    n_checks++; if (bus.IREADY !== 1'b1) begin n_fail++; $display("FAIL release_iready_after_edge: got %b want 1", bus.IREADY); end
  endtask

  task automatic test_basic();
    frame_words[0] = 8'h00; frame_words[1] = 8'h00; frame_words[2] = 8'h1F; frame_words[3] = 8'hFF;
    run_frame(4, 4, 0, 0, 0, 0);
    n_checks++; if (r_timeout) begin n_fail++; $display("FAIL basic_timeout: got timeout want OVALID"); end
    n_checks++; if (r_count !== 19) begin n_fail++; $display("FAIL basic_count: got %0d want 19", r_count); end
    n_checks++; if (r_all_same !== 1'b0) begin n_fail++; $display("FAIL basic_all_same: got %b want 0", r_all_same); end
    n_checks++; if (r_beats != 4) begin n_fail++; $display("FAIL basic_beats: got %0d want 4", r_beats); end
    n_checks++; if (r_lat != 1) begin n_fail++; $display("FAIL basic_latency: got %0d want 1", r_lat); end
    n_checks++; if (r_ovalid_after !== 1'b0) begin n_fail++; $display("FAIL basic_ovalid_after_hs: got %b want 0", r_ovalid_after); end
`ifdef LZC_FIRST_IDX_EN
    n_checks++; if (r_fidx !== 8'd2) begin n_fail++; $display("FAIL basic_first_idx: got %0d want 2", r_fidx); end
`endif
  endtask

  task automatic test_mode_early();
    frame_words[0] = 8'h00; frame_words[1] = 8'h00; frame_words[2] = 8'h1F; frame_words[3] = 8'hFF;
    run_frame(4, 4, 1, 0, 0, 2);
    n_checks++; if (r_count !== 19) begin n_fail++; $display("FAIL mode_count: got %0d want 19", r_count); end
    n_checks++; if (r_beats != 3) begin n_fail++; $display("FAIL mode_beats: got %0d want 3", r_beats); end
    n_checks++; if (r_iready_done !== 1'b0) begin n_fail++; $display("FAIL mode_iready_done: got %b want 0", r_iready_done); end
    n_checks++; if (!r_stable) begin n_fail++; $display("FAIL mode_stable: got unstable want stable"); end
    n_checks++; if (r_lat != 1) begin n_fail++; $display("FAIL mode_latency: got %0d want 1", r_lat); end
  endtask

  task automatic test_pol();
    frame_words[0] = 8'hFF; frame_words[1] = 8'hE0;
    run_frame(2, 2, 0, 1, 0, 0);
    n_checks++; if (r_count !== 11) begin n_fail++; $display("FAIL pol1_count: got %0d want 11", r_count); end
    n_checks++; if (r_all_same !== 1'b0) begin n_fail++; $display("FAIL pol1_all_same: got %b want 0", r_all_same); end
    frame_words[0] = 8'h00; frame_words[1] = 8'h00; frame_words[2] = 8'h00;
    run_frame(3, 3, 0, 0, 0, 0);
    n_checks++; if (r_count !== 24) begin n_fail++; $display("FAIL pol0_count: got %0d want 24", r_count); end
    n_checks++; if (r_all_same !== 1'b1) begin n_fail++; $display("FAIL pol0_all_same: got %b want 1", r_all_same); end
    n_checks++; if (r_beats != 3) begin n_fail++; $display("FAIL pol0_beats: got %0d want 3", r_beats); end
`ifdef LZC_FIRST_IDX_EN
    n_checks++; if (r_fidx !== 8'd0) begin n_fail++; $display("FAIL pol0_first_idx: got %0d want 0", r_fidx); end
`endif
  endtask

  task automatic test_nwords_limits();
    for (int w = 0; w < MAXW; w++) frame_words[w] = 8'h00;
    run_frame(4, 0, 0, 0, 0, 0);
    n_checks++; if (r_beats != 4) begin n_fail++; $display("FAIL nw0_beats: got %0d want 4", r_beats); end
    n_checks++; if (r_count !== 32) begin n_fail++; $display("FAIL nw0_count: got %0d want 32", r_count); end
    n_checks++; if (r_all_same !== 1'b1) begin n_fail++; $display("FAIL nw0_all_same: got %b want 1", r_all_same); end
    frame_words[3] = 8'h80;
    run_frame(4, 7, 0, 0, 0, 0);
    n_checks++; if (r_beats != 4) begin n_fail++; $display("FAIL nw7_beats: got %0d want 4", r_beats); end
    n_checks++; if (r_count !== 24) begin n_fail++; $display("FAIL nw7_count: got %0d want 24", r_count); end
`ifdef LZC_FIRST_IDX_EN
    n_checks++; if (r_fidx !== 8'd3) begin n_fail++; $display("FAIL nw7_first_idx: got %0d want 3", r_fidx); end
`endif
  endtask

  task automatic test_backpressure();
    frame_words[0] = 8'h00; frame_words[1] = 8'h03; frame_words[2] = 8'hFF; frame_words[3] = 8'h00;
    run_frame(4, 4, 0, 0, 50, 5);
    n_checks++; if (r_count !== 14) begin n_fail++; $display("FAIL bp_count: got %0d want 14", r_count); end
    n_checks++; if (r_beats != 4) begin n_fail++; $display("FAIL bp_beats: got %0d want 4", r_beats); end
    n_checks++; if (!r_stable) begin n_fail++; $display("FAIL bp_stable: got unstable want stable"); end
    n_checks++; if (r_iready_done !== 1'b0) begin n_fail++; $display("FAIL bp_iready_done: got %b want 0", r_iready_done); end
`ifdef LZC_FIRST_IDX_EN
    n_checks++; if (r_fidx !== 8'd1) begin n_fail++; $display("FAIL bp_first_idx: got %0d want 1", r_fidx); end
`endif
  endtask

  task automatic test_back_to_back();
    frame_words[0] = 8'h00; frame_words[1] = 8'h00; frame_words[2] = 8'h00;
    run_frame(3, 3, 0, 0, 0, 0);
    n_checks++; if (r_count !== 24) begin n_fail++; $display("FAIL b2b_a_count: got %0d want 24", r_count); end
    n_checks++; if (r_iready_after !== 1'b1) begin n_fail++; $display("FAIL b2b_iready_after_hs: got %b want 1", r_iready_after); end
    frame_words[0] = 8'h0F; frame_words[1] = 8'h00;
    run_frame(2, 2, 0, 0, 0, 0);
    n_checks++; if (r_count !== 4) begin n_fail++; $display("FAIL b2b_b_count: got %0d want 4", r_count); end
    n_checks++; if (r_cyc != 2) begin n_fail++; $display("FAIL b2b_b_cycles: got %0d want 2", r_cyc); end
  endtask

  task automatic test_reset_midframe();
    bus.MODE = 0; bus.POL = 0; bus.NWORDS = NW_W'(1); bus.OREADY = 0;
    bus.IVALID = 1; bus.DATA = 8'h00;
    @(negedge clk);
    bus.IVALID = 0;
    n_checks++; if (bus.OVALID !== 1'b1 || bus.COUNT !== 8) begin n_fail++; $display("FAIL rst_pre_done: got ovalid=%b count=%0d want 1/8", bus.OVALID, bus.COUNT); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.OVALID !== 1'b0) begin n_fail++; $display("FAIL rst_done_ovalid: got %b want 0", bus.OVALID); end
    n_checks++; if (bus.COUNT !== '0) begin n_fail++; $display("FAIL rst_done_count: got %0d want 0", bus.COUNT); end
    n_checks++; if (bus.ALL_SAME !== 1'b0) begin n_fail++; $display("FAIL rst_done_all_same: got %b want 0", bus.ALL_SAME); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    bus.NWORDS = NW_W'(4); bus.IVALID = 1; bus.DATA = 8'h00;
    repeat (2) @(negedge clk);
    bus.IVALID = 0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.IREADY !== 1'b0) begin n_fail++; $display("FAIL rst_mid_iready: got %b want 0", bus.IREADY); end
    n_checks++; if (bus.OVALID !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ovalid: got %b want 0", bus.OVALID); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    frame_words[0] = 8'h01; frame_words[1] = 8'h00; frame_words[2] = 8'h00; frame_words[3] = 8'h00;
    run_frame(4, 4, 0, 0, 0, 0);
    n_checks++; if (r_count !== 7) begin n_fail++; $display("FAIL rst_next_count: got %0d want 7", r_count); end
    n_checks++; if (r_beats != 4) begin n_fail++; $display("FAIL rst_next_beats: got %0d want 4", r_beats); end
`ifdef LZC_FIRST_IDX_EN
    n_checks++; if (r_fidx !== 8'd0) begin n_fail++; $display("FAIL rst_next_first_idx: got %0d want 0", r_fidx); end
`endif
  endtask

  task automatic test_random();
    int nw, gap, hold;
    bit mode, pol;
    for (int t = 0; t < 30; t++) begin
      nw = $urandom_range(0, 7); mode = 1'($urandom); pol = 1'($urandom);
      gap = $urandom_range(0, 50); hold = $urandom_range(0, 3);
      for (int w = 0; w < MAXW; w++) frame_words[w] = rand_word(pol);
      model(nw, mode, pol);
      run_frame(MAXW, nw, mode, pol, gap, hold);
      n_checks++; if (r_timeout) begin n_fail++; $display("FAIL rand%0d_timeout: got timeout want OVALID", t); end
      n_checks++; if (r_count !== CNT_W'(e_count)) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", t, r_count, e_count); end
      n_checks++; if (r_all_same !== e_all_same) begin n_fail++; $display("FAIL rand%0d_all_same: got %b want %b", t, r_all_same, e_all_same); end
      n_checks++; if (r_beats != e_beats) begin n_fail++; $display("FAIL rand%0d_beats: got %0d want %0d", t, r_beats, e_beats); end
      n_checks++; if (!r_stable) begin n_fail++; $display("FAIL rand%0d_stable: got unstable want stable", t); end
`ifdef LZC_FIRST_IDX_EN
      n_checks++; if (r_fidx !== 8'(e_fidx)) begin n_fail++; $display("FAIL rand%0d_first_idx: got %0d want %0d", t, r_fidx, e_fidx); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mode_early();
    test_pol();
    test_nwords_limits();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion want finish within 400us");
    $fatal(1, "watchdog expired");
  end

endmodule
